p17_app_line_buffer: RTL and testbench

- Application-side stage that consumes the OUT byte stream of the bulk endpoint (app_out_* side) and feeds the IN stream back (app_in_* side).
- Collects bytes into a line buffer until an end-of-line character or buffer full, then replays the whole line on the IN stream.
- Provides line-oriented echo/loopback for CDC bring-up and console-style applications.

---
 rtl/p17_app_line_buffer.sv | 122 ++++++++++++
 tb/tb_p17_app_line_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/p17_app_line_buffer.sv
// Line buffer between the bulk endpoint's OUT and IN application streams: collects bytes until EOL or full, then replays the line.
// Optional build macro P17_LINE_BUF_UPCASE_EN maps lowercase ASCII to uppercase on the replay path only.
module p17_app_line_buffer #(
    parameter int unsigned LINE_DEPTH = 64,
    parameter logic [7:0]  EOL_CHAR   = 8'h0D
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [7:0]                      out_data_i,
    input  logic                            out_valid_i,
    output logic                            out_ready_o,
    output logic [7:0]                      in_data_o,
    output logic                            in_valid_o,
    input  logic                            in_ready_i,
    output logic [$clog2(LINE_DEPTH+1)-1:0] line_len_o,
    output logic                            overflow_o
);

    localparam int unsigned PW = $clog2(LINE_DEPTH + 1);
    localparam int unsigned AW = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]    r_state;
    logic          r_active;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_len;
    logic          r_overflow;
    logic [7:0]    r_mem [LINE_DEPTH];

    logic          w_wr_fire;
    logic          w_rd_fire;
    logic          w_is_eol;
    logic          w_full;
    logic          w_last_rd;
    logic [PW-1:0] w_wr_next;
    logic [7:0]    w_raw;

    // Handshakes are decoded from registered state only, so the turnaround cycle never accepts a byte.
    assign out_ready_o = r_active && (r_state == ST_FILL);
    assign in_valid_o  = (r_state == ST_DRAIN);
    assign line_len_o  = r_len;
    assign overflow_o  = r_overflow;

    assign w_wr_fire = out_valid_i && out_ready_o;
    assign w_rd_fire = in_valid_o && in_ready_i;
    assign w_is_eol  = (out_data_i == EOL_CHAR);
    assign w_wr_next = r_wr_ptr + PW'(1);
    assign w_full    = (w_wr_next == PW'(LINE_DEPTH));
    assign w_last_rd = (r_rd_ptr == (r_len - PW'(1)));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn_i) begin
            r_state    <= ST_FILL;
            r_active   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_len      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                ST_FILL: begin
                    if (w_wr_fire) begin
                        r_wr_ptr <= w_wr_next;
                        // A final byte that is both EOL and buffer-full counts as a clean EOL.
                        if (w_is_eol) begin
                            r_state    <= ST_DRAIN;
                            r_rd_ptr   <= '0;
                            r_len      <= w_wr_next;
                            r_overflow <= 1'b0;
                        end else if (w_full) begin
                            r_state    <= ST_DRAIN;
                            r_rd_ptr   <= '0;
                            r_len      <= PW'(LINE_DEPTH);
                            r_overflow <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_rd_fire) begin
                        if (w_last_rd) begin
                            r_state    <= ST_FILL;
                            r_wr_ptr   <= '0;
                            r_rd_ptr   <= '0;
                            r_len      <= '0;
                            r_overflow <= 1'b0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + PW'(1);
                        end
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    // NOTE: the storage array has no reset; every location is written in FILL before DRAIN can read it.
    always_ff @(posedge clk_i) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr[AW-1:0]] <= out_data_i;
        end
    end

    assign w_raw = r_mem[r_rd_ptr[AW-1:0]];

`ifdef P17_LINE_BUF_UPCASE_EN
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        in_data_o = w_raw;
        if ((w_raw >= 8'h61) && (w_raw <= 8'h7A)) begin
            in_data_o = w_raw - 8'h20;
        end
    end
`else
    assign in_data_o = w_raw;
`endif

endmodule

// File: tb/tb_p17_app_line_buffer.sv
// Directed self-checking bench for p17_app_line_buffer (LINE_DEPTH=64, EOL=0x0D).
module tb_p17_app_line_buffer;

    localparam int unsigned LD = 64;
    localparam int unsigned LW = $clog2(LD + 1);

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic [7:0]    out_data_i = 8'h00;
    logic          out_valid_i = 1'b0;
    logic          out_ready_o;
    logic [7:0]    in_data_o;
    logic          in_valid_o;
    logic          in_ready_i = 1'b0;
    logic [LW-1:0] line_len_o;
    logic          overflow_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    p17_app_line_buffer #(.LINE_DEPTH(LD), .EOL_CHAR(8'h0D)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .out_data_i  (out_data_i),
        .out_valid_i (out_valid_i),
        .out_ready_o (out_ready_o),
        .in_data_o   (in_data_o),
        .in_valid_o  (in_valid_o),
        .in_ready_i  (in_ready_i),
        .line_len_o  (line_len_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] map_b(input logic [7:0] b);
`ifdef P17_LINE_BUF_UPCASE_EN
        if ((b >= 8'h61) && (b <= 8'h7A)) return b - 8'h20;
`endif
        return b;
    endfunction

    // Called at a sample point (#1 after a rising edge); returns at the sample point after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        out_data_i  = b;
        out_valid_i = 1'b1;
        while (!out_ready_o && n < 300) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!out_ready_o) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk_i); #1;
        out_valid_i = 1'b0;
    endtask

    task automatic recv_line(input string tag, input int exp_len, input logic exp_ovf, input bit toggle);
        int   i = 0;
        int   guard = 0;
        logic rdy = 1'b0;
        while (i < exp_q.size() && guard < 1000) begin
            rdy = toggle ? ~rdy : 1'b1;
            in_ready_i = rdy;
            if (in_valid_o) begin
                check({tag, "_data"}, in_data_o, map_b(exp_q[i]));
                check({tag, "_len"}, line_len_o, exp_len);
                check({tag, "_ovf"}, overflow_o, exp_ovf);
                check({tag, "_ordy"}, out_ready_o, 32'd0);
                if (rdy) i++;
            end
            @(posedge clk_i); #1;
            guard++;
        end
        in_ready_i = 1'b0;
        check({tag, "_count"}, i, exp_q.size());
        check({tag, "_ivld_end"}, in_valid_o, 32'd0);
        check({tag, "_ordy_end"}, out_ready_o, 32'd1);
        check({tag, "_len_end"}, line_len_o, 32'd0);
        check({tag, "_ovf_end"}, overflow_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, then release away from the clock edge.
        #12;
        check("rst_ordy", out_ready_o, 32'd0);
        check("rst_ivld", in_valid_o, 32'd0);
        check("rst_len", line_len_o, 32'd0);
        check("rst_ovf", overflow_o, 32'd0);
        @(negedge clk_i); rstn_i = 1'b1; #1;
        check("rel_ordy_pre", out_ready_o, 32'd0);
        @(posedge clk_i); #1;
        check("rel_ordy_post", out_ready_o, 32'd1);

        // "hi\r" with in_ready held high.
        in_ready_i = 1'b1;
        exp_q = '{8'h68, 8'h69, 8'h0D};
        foreach (exp_q[k]) send_byte(exp_q[k]);
        recv_line("hi", 3, 1'b0, 1'b0);

        // 64 bytes without EOL; the next byte (0x0D) is held on the OUT side throughout the drain.
        exp_q = {};
        for (int k = 0; k < 64; k++) exp_q.push_back(8'(8'h40 + k));
        foreach (exp_q[k]) send_byte(exp_q[k]);
        out_data_i  = 8'h0D;
        out_valid_i = 1'b1;
        recv_line("full", 64, 1'b1, 1'b0);

        // The held 0x0D becomes a one-byte line.
        exp_q = '{8'h0D};
        send_byte(8'h0D);
        recv_line("single", 1, 1'b0, 1'b0);

        // "abc\r" with in_ready toggling every cycle.
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h0D};
        foreach (exp_q[k]) send_byte(exp_q[k]);
        recv_line("abc", 4, 1'b0, 1'b1);

        // Reset after two of five bytes drained.
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D};
        foreach (exp_q[k]) send_byte(exp_q[k]);
        check("rst_mid_first", in_data_o, 32'h41);
        in_ready_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("rst_mid_third", in_data_o, 32'h43);
        check("rst_mid_len", line_len_o, 32'd5);
        in_ready_i = 1'b0;
        rstn_i = 1'b0;
        #1;
        check("rst_mid_ivld", in_valid_o, 32'd0);
        check("rst_mid_ordy", out_ready_o, 32'd0);
        check("rst_mid_len0", line_len_o, 32'd0);
        @(negedge clk_i); rstn_i = 1'b1; #1;
        check("rst_mid_ordy_pre", out_ready_o, 32'd0);
        @(posedge clk_i); #1;
        check("rst_mid_ordy_post", out_ready_o, 32'd1);
        exp_q = '{8'h5A, 8'h0D};
        foreach (exp_q[k]) send_byte(exp_q[k]);
        recv_line("z", 2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
